// File: rtl/grid_pio_poller.sv
// ---------------------------------------------------------------------------
// grid_pio_poller
//
// Polls one GPIO data register on an Avalon-MM master port at a programmable
// interval. It records every bit that toggled between consecutive samples into
// a sticky PENDING register and raises a level interrupt for unmasked pending
// bits.
//
// Ports
//   csi_MCLK_clk          sole clock, rising edge
//   rsi_MRST_reset_n      asynchronous active-low reset
//   avs_ctrl_*            control slave: 3-bit word address, 32-bit data,
//                         zero wait states, combinational readback
//   avm_gpio_*            read-only master port towards the GPIO block
//   ins_INTRQ_irq         registered level interrupt, |(PENDING & MASK)
//
// Control register map (word addresses)
//   0 CTRL     bit0 EN (RW), other bits read 0
//   1 PERIOD   bits 23:0 (RW), poll interval in clocks (0 treated as 1)
//   2 MASK     32-bit interrupt mask (RW)
//   3 PENDING  32-bit change flags, write-1-to-clear
//   4 SAMPLE   last accepted GPIO sample (RO)
//   5-7        read 0, writes ignored
// ---------------------------------------------------------------------------
module grid_pio_poller #(
    parameter logic [4:0]  GPIO_ADDR  = 5'd0,
    parameter logic [23:0] PERIOD_RST = 24'd1000
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,

    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic        avs_ctrl_read,
    output logic [31:0] avs_ctrl_readdata,

    output logic [4:0]  avm_gpio_address,
    output logic        avm_gpio_read,
    output logic        avm_gpio_write,
    output logic [31:0] avm_gpio_writedata,
    output logic [3:0]  avm_gpio_byteenable,
    input  logic [31:0] avm_gpio_readdata,
    input  logic        avm_gpio_waitrequest,

    output logic        ins_INTRQ_irq
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_CMP  = 2'd3;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_PERIOD  = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_PENDING = 3'd3;
    localparam logic [2:0] ADDR_SAMPLE  = 3'd4;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]  state_reg,   state_next;
    logic [23:0] cnt_reg,     cnt_next;
    logic [31:0] cap_reg,     cap_next;
    logic [31:0] sample_reg,  sample_next;
    logic        primed_reg,  primed_next;
    logic        drop_reg,    drop_next;
    logic [31:0] pending_reg, pending_next;
    logic        en_reg;
    logic [23:0] period_reg;
    logic [31:0] mask_reg;
    logic        irq_reg;

    // -----------------------------------------------------------------------
    // Control-slave write decode
    // -----------------------------------------------------------------------
    logic        wr_ctrl;
    logic        wr_period;
    logic        wr_mask;
    logic        wr_pending;
    logic        en_fall;
    logic [31:0] pend_clr;
    logic [31:0] pend_set;
    logic [23:0] load_val;

    assign wr_ctrl    = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL);
    assign wr_period  = avs_ctrl_write && (avs_ctrl_address == ADDR_PERIOD);
    assign wr_mask    = avs_ctrl_write && (avs_ctrl_address == ADDR_MASK);
    assign wr_pending = avs_ctrl_write && (avs_ctrl_address == ADDR_PENDING);

    // EN 1->0 transition caused by a CTRL write this cycle.
    assign en_fall  = wr_ctrl && en_reg && !avs_ctrl_writedata[0];
    assign pend_clr = wr_pending ? avs_ctrl_writedata : 32'd0;

    // PERIOD of 0 would make the countdown meaningless; it polls as if 1.
    assign load_val = (period_reg == 24'd0) ? 24'd1 : period_reg;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        cap_next    = cap_reg;
        sample_next = sample_reg;
        primed_next = primed_reg;
        pend_set    = 32'd0;

        case (state_reg)
            ST_IDLE: begin
                if (en_reg) begin
                    cnt_next   = load_val;
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!en_reg) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg <= 24'd1) begin
                    // The cycle spent at count 1 is the last WAIT cycle, so
                    // WAIT lasts exactly load_val cycles.
                    cnt_next   = 24'd0;
                    state_next = ST_READ;
                end else begin
                    cnt_next = cnt_reg - 24'd1;
                end
            end

            ST_READ: begin
                // The transfer always runs to completion; if EN dropped at any
                // point during it, the returned word is thrown away.
                if (!avm_gpio_waitrequest) begin
                    if (drop_reg || !en_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        cap_next   = avm_gpio_readdata;
                        state_next = ST_CMP;
                    end
                end
            end

            ST_CMP: begin
                if (en_reg) begin
                    if (primed_reg) begin
                        pend_set = cap_reg ^ sample_reg;
                    end
                    sample_next = cap_reg;
                    primed_next = 1'b1;
                    cnt_next    = load_val;
                    state_next  = ST_WAIT;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Disabling always forgets the reference sample, even if a CMP in
        // this very cycle would have primed it.
        if (en_fall) begin
            primed_next = 1'b0;
        end
    end

    // Remember an EN drop that happens while a read is outstanding.
    assign drop_next = (state_reg == ST_READ) ? (drop_reg | en_fall) : 1'b0;

    // PENDING: a set from CMP beats a simultaneous write-1-to-clear.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pending
            assign pending_next[gi] = pend_set[gi] | (pending_reg[gi] & ~pend_clr[gi]);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 24'd0;
            cap_reg     <= 32'd0;
            sample_reg  <= 32'd0;
            primed_reg  <= 1'b0;
            drop_reg    <= 1'b0;
            pending_reg <= 32'd0;
            irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cap_reg     <= cap_next;
            sample_reg  <= sample_next;
            primed_reg  <= primed_next;
            drop_reg    <= drop_next;
            pending_reg <= pending_next;
            irq_reg     <= |(pending_reg & mask_reg);
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            en_reg     <= 1'b0;
            period_reg <= PERIOD_RST;
            mask_reg   <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                en_reg <= avs_ctrl_writedata[0];
            end
            if (wr_period) begin
                period_reg <= avs_ctrl_writedata[23:0];
            end
            if (wr_mask) begin
                mask_reg <= avs_ctrl_writedata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control-slave readback (combinational, zero wait states). The bus is
    // driven to zero outside read cycles to keep shared read muxes quiet.
    // -----------------------------------------------------------------------
    always_comb begin
        avs_ctrl_readdata = 32'd0;
        if (avs_ctrl_read) begin
            case (avs_ctrl_address)
                ADDR_CTRL:    avs_ctrl_readdata = {31'd0, en_reg};
                ADDR_PERIOD:  avs_ctrl_readdata = {8'd0, period_reg};
                ADDR_MASK:    avs_ctrl_readdata = mask_reg;
                ADDR_PENDING: avs_ctrl_readdata = pending_reg;
                ADDR_SAMPLE:  avs_ctrl_readdata = sample_reg;
                default:      avs_ctrl_readdata = 32'd0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Master port: read-only. The strobe is decoded straight from the state
    // register so that reset removes it without waiting for a clock edge.
    // -----------------------------------------------------------------------
    assign avm_gpio_address    = GPIO_ADDR;
    assign avm_gpio_read       = (state_reg == ST_READ);
    assign avm_gpio_write      = 1'b0;
    assign avm_gpio_writedata  = 32'd0;
    assign avm_gpio_byteenable = 4'hF;

    assign ins_INTRQ_irq = irq_reg;

endmodule

// File: doc/grid_pio_poller.md
GRID_PIO_POLLER -- requirements
Module: grid_pio_poller

Interface
REQ-001 SHALL have parameter GPIO_ADDR, default 5'd0: word address of the polled GPIO data register on the master port.
REQ-002 SHALL have parameter PERIOD_RST, default 24'd1000: reset value of the PERIOD register.
REQ-003 csi_MCLK_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rsi_MRST_reset_n  in  1  asynchronous, active-low reset.
REQ-005 avs_ctrl_address  in  3  control-slave word address.
REQ-006 avs_ctrl_write  in  1; avs_ctrl_writedata  in  32; avs_ctrl_read  in  1  control-slave access.
REQ-007 avs_ctrl_readdata  out  32  combinational register readback; no waitrequest, zero wait states.
REQ-008 avm_gpio_address  out  5  constant GPIO_ADDR.
REQ-009 avm_gpio_read  out  1; avm_gpio_write  out  1 (tied 0); avm_gpio_writedata  out  32 (tied 0); avm_gpio_byteenable  out  4 (tied 4'hF).
REQ-010 avm_gpio_readdata  in  32; avm_gpio_waitrequest  in  1  master-port response.
REQ-011 ins_INTRQ_irq  out  1  level interrupt.

Function
REQ-012 Control registers SHALL be: 0 CTRL (bit0 EN, RW; other bits read 0); 1 PERIOD (bits 23:0, RW); 2 MASK (32 bits, RW); 3 PENDING (32 bits, write-1-to-clear); 4 SAMPLE (32 bits, RO); 5-7 read 0 and ignore writes.
REQ-013 The FSM SHALL have states IDLE, WAIT, READ, CMP.
REQ-014 IDLE: avm_gpio_read=0; when EN=1, load the counter with max(PERIOD,1) and go to WAIT.
REQ-015 WAIT: decrement the counter each cycle; on the cycle the counter reaches 1, go to READ; EN=0 -> IDLE immediately.
REQ-016 READ: hold avm_gpio_read=1 with a stable address until a cycle with waitrequest=0, capture avm_gpio_readdata in that cycle, then go to CMP.
REQ-017 A read SHALL NOT be aborted: EN=0 during READ completes the transfer, discards the data, and goes to IDLE.
REQ-018 CMP (one cycle): PENDING |= (captured ^ SAMPLE) only if the PRIMED flag is set; then SAMPLE <= captured, PRIMED <= 1, reload the counter with max(PERIOD,1), go to WAIT (or to IDLE if EN=0).
REQ-019 PRIMED SHALL clear on reset and on every EN 1->0 transition, so the first sample after enable never sets PENDING.
REQ-020 With zero waitrequest, read strobes SHALL be spaced exactly max(PERIOD,1)+2 cycles apart; PERIOD=0 behaves as PERIOD=1.
REQ-021 A PERIOD write SHALL take effect at the next counter load and SHALL NOT alter a countdown in progress.
REQ-022 When a W1C clear and a CMP set hit the same PENDING bit in the same cycle, set SHALL win.
REQ-023 ins_INTRQ_irq SHALL be registered, equal to |(PENDING & MASK) one cycle after PENDING/MASK change.

Reset
REQ-024 While rsi_MRST_reset_n=0: state=IDLE, avm_gpio_read=0, irq=0, EN=0, PERIOD=PERIOD_RST, MASK=0, PENDING=0, SAMPLE=0, PRIMED=0, counter=0.
REQ-025 Reset asserted mid-READ SHALL drop avm_gpio_read asynchronously; the block SHALL resume only through IDLE after release.

Verification
REQ-026 PERIOD=3, EN=1, waitrequest=0, slave data constant 0x5 -> read strobes every 5 cycles, SAMPLE=0x5, PENDING stays 0, irq=0.
REQ-027 MASK=0x1, slave data changes 0x5->0x4 -> PENDING=0x1 after the next CMP, irq=1 one cycle later; write PENDING=0x1 -> PENDING=0, irq=0.
REQ-028 waitrequest held high 4 cycles during READ -> avm_gpio_read stays 1 for 5 cycles, data captured only on the waitrequest=0 cycle.
REQ-029 EN cleared during READ with waitrequest high -> read completes, SAMPLE unchanged, state IDLE; re-enable with different slave data -> PENDING stays 0 on first sample.
REQ-030 W1C of bit0 in the same cycle CMP sets bit0 -> PENDING bit0=1 and irq remains 1.
REQ-031 PERIOD=0 -> strobes every 3 cycles; reset pulse mid-WAIT -> all registers at REQ-024 values, no read until EN rewritten.
